// File: rtl/core_reset_pkg.sv
// Shared types and constants for the core reset sequencer.
package core_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // Cause bits above the req_i field: cause_o[NSRC + CAUSE_x]
  localparam int unsigned CAUSE_PLL  = 0;
  localparam int unsigned CAUSE_MODE = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rstseq_sync.sv
// Two-flop synchroniser with asynchronous active-low clear to zero.
module rstseq_sync #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/core_reset_seq.sv
// Staged multi-domain reset sequencer: hold after triggers clear, then release domains in order.
// Define RSTSEQ_CAUSE_EN to build the sticky reset-cause register; otherwise cause_o is 0.
module core_reset_seq
  import core_reset_pkg::*;
#(
  parameter int unsigned NSRC        = 3,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned NDOM        = 3,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic [NSRC-1:0]   req_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [NDOM-1:0]   rst_o,
  output logic              ready_o,
  output logic [NSRC+1:0]   cause_o
);

  localparam int unsigned CNT_W   = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int unsigned STG_W   = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam int unsigned CAUSE_W = NSRC + 2;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NDOM - 1);

  logic              w_pll_sync;
  logic [NSRC-1:0]   w_req_sync;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] r_mode_prev;
  logic              r_primed;
  logic              w_trig_mode;
  logic              w_trigger;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [STG_W-1:0]  r_stage, w_stage_nxt;
  logic [NDOM-1:0]   r_rst, w_rst_nxt;
  logic              r_ready, w_ready_nxt;

  rstseq_sync #(.W(1)) u_sync_pll (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_pll_sync)
  );

  rstseq_sync #(.W(NSRC)) u_sync_req (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_d     (req_i),
    .o_q     (w_req_sync)
  );

  // First edge out of reset loads both mode registers so no false change is seen.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mode      <= '0;
      r_mode_prev <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_mode      <= mode_i;
      r_mode_prev <= r_primed ? r_mode : mode_i;
      r_primed    <= 1'b1;
    end
  end

  assign w_trig_mode = (r_mode != r_mode_prev);
  assign w_trigger   = ~w_pll_sync | (|w_req_sync) | w_trig_mode;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_stage <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_rst   <= w_rst_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next state; the counter only moves while non-zero, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst;
    w_ready_nxt = r_ready;
    case (r_state)
      ST_ASSERT: begin
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (!w_trigger) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (w_trigger) begin
          w_state_nxt = ST_ASSERT;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RELEASE;
          w_stage_nxt = '0;
          w_cnt_nxt   = GAP_LOAD;
          w_rst_nxt[0] = 1'b0;
          if (w_stage_nxt == LAST_STG) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (w_trigger) begin
          w_state_nxt = ST_ASSERT;
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
        end else if (r_cnt == '0) begin
          w_stage_nxt = r_stage + STG_W'(1);
          w_cnt_nxt   = GAP_LOAD;
          w_rst_nxt[w_stage_nxt] = 1'b0;
          if (w_stage_nxt == LAST_STG) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (w_trigger) begin
          w_state_nxt = ST_ASSERT;
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_ASSERT;
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign rst_o   = r_rst;
  assign ready_o = r_ready;

`ifdef RSTSEQ_CAUSE_EN
  logic [CAUSE_W-1:0] w_trig_vec;
  logic [CAUSE_W-1:0] r_cause;
  logic               w_cause_load;

  always_comb begin
    w_trig_vec                    = '0;
    w_trig_vec[NSRC-1:0]          = w_req_sync;
    w_trig_vec[NSRC + CAUSE_PLL]  = ~w_pll_sync;
    w_trig_vec[NSRC + CAUSE_MODE] = w_trig_mode;
  end

  // The first edge after reset counts as an ASSERT entry so power-up causes are captured.
  assign w_cause_load = (w_state_nxt == ST_ASSERT) && ((r_state != ST_ASSERT) || !r_primed);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cause <= '0;
    end else if (w_cause_load) begin
      r_cause <= w_trig_vec;
    end
  end

  assign cause_o = r_cause;
`else
  assign cause_o = '0;
`endif

endmodule

// File: tb/tb_core_reset_seq.sv
// Bench for core_reset_seq: directed vector table plus random stimulus against a release-timeline model.
module tb_core_reset_seq;

  localparam int NSRC   = 3;
  localparam int MODE_W = 2;
  localparam int NDOM   = 3;
  localparam int HOLD   = 8;
  localparam int GAP    = 4;
  localparam int Q_MAX  = 1 + HOLD + (NDOM - 1) * GAP;
`ifdef RSTSEQ_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              pll_locked;
  logic [NSRC-1:0]   req_i;
  logic [MODE_W-1:0] mode_i;
  logic [NDOM-1:0]   rst_o;
  logic              ready_o;
  logic [NSRC+1:0]   cause_o;

  always #5 clk_sys = ~clk_sys;

  core_reset_seq #(
    .NSRC(NSRC), .MODE_W(MODE_W), .NDOM(NDOM), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .req_i      (req_i),
    .mode_i     (mode_i),
    .rst_o      (rst_o),
    .ready_o    (ready_o),
    .cause_o    (cause_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_q counts consecutive trigger-free edges; domain k is out of reset once m_q >= 1+HOLD+k*GAP.
  int              m_q;
  bit              m_first;
  logic            m_pll_s1, m_pll_s2;
  logic [NSRC-1:0] m_req_s1, m_req_s2;
  logic [1:0]      m_mode_h0, m_mode_h1;
  int              m_nmode;
  logic [4:0]      m_cause;

  task automatic model_reset();
    m_q = 0; m_first = 1'b1;
    m_pll_s1 = 1'b0; m_pll_s2 = 1'b0;
    m_req_s1 = '0;   m_req_s2 = '0;
    m_mode_h0 = '0;  m_mode_h1 = '0; m_nmode = 0;
    m_cause = '0;
  endtask

  task automatic model_edge();
    logic [4:0] vec;
    vec = {((m_nmode >= 2) && (m_mode_h0 != m_mode_h1)), ~m_pll_s2, m_req_s2};
    if (|vec) begin
      if (m_q != 0 || m_first) m_cause = vec;
      m_q = 0;
    end else if (m_q < Q_MAX) begin
      m_q++;
    end
    m_first = 1'b0;
    m_pll_s2 = m_pll_s1; m_pll_s1 = pll_locked;
    m_req_s2 = m_req_s1; m_req_s1 = req_i;
    m_mode_h1 = m_mode_h0; m_mode_h0 = mode_i;
    if (m_nmode < 2) m_nmode++;
  endtask

  task automatic check(input string name, input logic [NDOM-1:0] e_rst,
                       input logic e_rdy, input logic [4:0] e_cause);
    n_tests++;
    if (rst_o !== e_rst || ready_o !== e_rdy || cause_o !== e_cause) begin
      n_fail++;
      $display("FAIL %s @%0t: rst_o=%b ready_o=%b cause_o=%b, expected rst_o=%b ready_o=%b cause_o=%b",
               name, $time, rst_o, ready_o, cause_o, e_rst, e_rdy, e_cause);
    end
  endtask

  task automatic check_model(input string name);
    logic [NDOM-1:0] e_rst;
    for (int k = 0; k < NDOM; k++) e_rst[k] = (m_q < 1 + HOLD + k * GAP);
    check(name, e_rst, (m_q >= Q_MAX), CAUSE_EN ? m_cause : 5'b0);
  endtask

  task automatic step(input logic pll, input logic [NSRC-1:0] req, input logic [1:0] mode);
    @(negedge clk_sys);
    reset_n = 1'b1; pll_locked = pll; req_i = req; mode_i = mode;
    @(posedge clk_sys);
    model_edge();
    #1;
    check_model("model");
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", 3'b111, 1'b0, 5'b0);
  endtask

  typedef struct {
    logic       pll;
    logic [2:0] req;
    logic [1:0] mode;
    int         n;
    logic [2:0] rst;
    logic       rdy;
    logic [4:0] cause;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [1:0] cur_mode;
    logic [2:0] rreq;

    // power-up: PLL unlocked 20 cycles, then staged release
    tbl.push_back('{1'b0, 3'b000, 2'b00, 20, 3'b111, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00, 10, 3'b111, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b110, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  3, 3'b110, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b100, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  3, 3'b100, 1'b0, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b000, 1'b1, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  5, 3'b000, 1'b1, 5'b01000});
    // one-cycle req_i[1] pulse: reset on the 3rd edge
    tbl.push_back('{1'b1, 3'b010, 2'b00,  1, 3'b000, 1'b1, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b000, 1'b1, 5'b01000});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b111, 1'b0, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  8, 3'b111, 1'b0, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b110, 1'b0, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  7, 3'b100, 1'b0, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  1, 3'b000, 1'b1, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b00,  3, 3'b000, 1'b1, 5'b00010});
    // mode change 00 -> 01, then held stable
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b000, 1'b1, 5'b00010});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b111, 1'b0, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  8, 3'b111, 1'b0, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b110, 1'b0, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  7, 3'b100, 1'b0, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b000, 1'b1, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01, 10, 3'b000, 1'b1, 5'b10000});
    // req_i[0], then reasserted while the hold count is 3
    tbl.push_back('{1'b1, 3'b001, 2'b01,  1, 3'b000, 1'b1, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b000, 1'b1, 5'b10000});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b111, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  3, 3'b111, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b001, 2'b01,  1, 3'b111, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  2, 3'b111, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  8, 3'b111, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b110, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  4, 3'b100, 1'b0, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  4, 3'b000, 1'b1, 5'b00001});
    // req_i[2] to reach mid-release before the async reset
    tbl.push_back('{1'b1, 3'b100, 2'b01,  1, 3'b000, 1'b1, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b000, 1'b1, 5'b00001});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b111, 1'b0, 5'b00100});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  8, 3'b111, 1'b0, 5'b00100});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  1, 3'b110, 1'b0, 5'b00100});
    tbl.push_back('{1'b1, 3'b000, 2'b01,  5, 3'b100, 1'b0, 5'b00100});

    reset_n = 1'b0; pll_locked = 1'b0; req_i = '0; mode_i = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_state", 3'b111, 1'b0, 5'b0);

    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(tbl[i].pll, tbl[i].req, tbl[i].mode);
      check($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rdy, CAUSE_EN ? tbl[i].cause : 5'b0);
    end

    // async reset mid-release, then recovery with mode_i=01 held
    async_reset();
    repeat (18) step(1'b1, 3'b000, 2'b01);
    check("post_rst_partial", 3'b100, 1'b0, CAUSE_EN ? 5'b01000 : 5'b0);
    step(1'b1, 3'b000, 2'b01);
    check("post_rst_run", 3'b000, 1'b1, CAUSE_EN ? 5'b01000 : 5'b0);
    repeat (10) step(1'b1, 3'b000, 2'b01);
    check("post_rst_stable", 3'b000, 1'b1, CAUSE_EN ? 5'b01000 : 5'b0);

    // random phase
    cur_mode = 2'b01;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NSRC; b++) rreq[b] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) cur_mode = 2'($urandom);
      step(($urandom_range(0, 79) != 0), rreq, cur_mode);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
